// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with ready handshakes to imem/dmem.
// Latency: branch 3 cycles, ALU/U-type/jal/jalr/store 4, load 5, plus memory wait states.
// Backpressure: imem_req/dmem_req held until ready; MEM_TIMEOUT wait cycles -> sticky bus_err, HALT.
// Build option: define ILLEGAL_TRAP_EN to trap (sticky, HALT) on unknown opcodes instead of NOP.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src,
  output logic [1:0] pc_src,
  output logic [2:0] mem_to_reg,
  output logic       bus_err,
  output logic       trap
);

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t           state_q, state_n;
  logic [6:0]       opc_q;
  logic [TMO_W-1:0] timer_q;
  logic             bus_err_q;
  logic             bus_err_set;
  logic             mem_wait;
  logic             tmo_hit;
`ifdef ILLEGAL_TRAP_EN
  logic             trap_q;
  logic             trap_set;
`endif

  // A request is outstanding and the memory has not answered this cycle
  assign mem_wait = ((state_q == S_FETCH) && !imem_ready) ||
                    ((state_q == S_MEM)   && !dmem_ready);
  // This waiting cycle is the last one allowed; a ready in the same cycle wins instead
  assign tmo_hit  = (MEM_TIMEOUT != 0) && mem_wait &&
                    (timer_q == TMO_W'(MEM_TIMEOUT - 1));

  // State, latched opcode, wait timer and sticky bus error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opc_q     <= 7'd0;
      timer_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_q == S_DECODE) opc_q <= opcode;
      if ((state_n != state_q) && ((state_n == S_FETCH) || (state_n == S_MEM)))
        timer_q <= '0;
      else if (mem_wait)
        timer_q <= timer_q + TMO_W'(1);
      if (bus_err_set) bus_err_q <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)           trap_q <= 1'b0;
    else if (trap_set) trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign bus_err = bus_err_q;

  // Next state and datapath controls from state plus latched opcode
  always_comb begin
    state_n     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_op      = 2'b00;
    alu_src     = 2'd0;
    pc_src      = 2'b00;
    mem_to_reg  = 3'b000;
    bus_err_set = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap_set    = 1'b0;
`endif

    // ALU and writeback-source selects stay stable from EXEC through WB
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      case (opc_q)
        OP_R:      alu_op = 2'b11;
        OP_I:      begin alu_op = 2'b10; alu_src = 2'd1; end
        OP_LOAD:   begin alu_src = 2'd1; mem_to_reg = 3'b001; end
        OP_STORE:  alu_src = 2'd2;
        OP_BRANCH: alu_op = 2'b01;
        OP_JAL,
        OP_JALR:   mem_to_reg = 3'b010;
        OP_LUI:    mem_to_reg = 3'b011;
        OP_AUIPC:  mem_to_reg = 3'b100;
        default:   ;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_n  = S_DECODE;
        end else if (tmo_hit) begin
          bus_err_set = 1'b1;
          state_n     = S_HALT;
        end
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        case (opc_q)
          OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_n = S_WB;
          OP_LOAD, OP_STORE: state_n = S_MEM;
          OP_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'b01 : 2'b00;
            state_n  = S_FETCH;
          end
          default: begin
`ifdef ILLEGAL_TRAP_EN
            trap_set = 1'b1;
            state_n  = S_HALT;
`else
            pc_write = 1'b1;
            state_n  = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = (opc_q == OP_LOAD);
        mem_write = (opc_q == OP_STORE);
        if (dmem_ready) begin
          if (opc_q == OP_LOAD) begin
            state_n = S_WB;
          end else begin
            pc_write = 1'b1;
            state_n  = S_FETCH;
          end
        end else if (tmo_hit) begin
          bus_err_set = 1'b1;
          state_n     = S_HALT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (opc_q == OP_JAL)       pc_src = 2'b10;
        else if (opc_q == OP_JALR) pc_src = 2'b11;
        state_n = S_FETCH;
      end
      default: state_n = S_HALT;
    endcase

    // A reset cycle aborts the instruction in flight: no strobes escape
    if (rst) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_op     = 2'b00;
      alu_src    = 2'd0;
      pc_src     = 2'b00;
      mem_to_reg = 3'b000;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  localparam int TMO = 16;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic [1:0] alu_src;
    logic [1:0] pc_src;
    logic [2:0] mem_to_reg;
    logic       bus_err;
    logic       trap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, branch_taken, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic       imem_req, dmem_req, ir_write, pc_write, reg_write, mem_read, mem_write;
  logic [1:0] alu_op, alu_src, pc_src;
  logic [2:0] mem_to_reg;
  logic       bus_err, trap;

  multicycle_control_unit #(.MEM_TIMEOUT(TMO), .TMO_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_op(alu_op), .alu_src(alu_src),
    .pc_src(pc_src), .mem_to_reg(mem_to_reg), .bus_err(bus_err), .trap(trap)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  exp_t msk_q[$];
  exp_t m_full, m_strb;
  logic m_bus_err = 1'b0;
  logic m_trap    = 1'b0;

  // Observed instruction shape, used to pin the model with literal numbers
  int   ilen = 0, last_len = 0, dreq_cnt = 0, wait_run = 0, tmo_len = 0;
  logic bus_err_prev = 1'b0;

  // Compare DUT outputs against the model's expectation for this cycle
  always @(negedge clk) begin
    exp_t act, e, m;
    cyc = cyc + 1;
    act = {imem_req, dmem_req, ir_write, pc_write, reg_write, mem_read, mem_write,
           alu_op, alu_src, pc_src, mem_to_reg, bus_err, trap};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n_cmp = n_cmp + 1;
      if (((act ^ e) & m) != '0) begin
        n_bad = n_bad + 1;
        $display("FAIL outputs @cycle %0d: got %h expected %h (mask %h)", cyc, act, e, m);
      end
    end
    if (ir_write) begin ilen = 1; dreq_cnt = 0; end
    else ilen = ilen + 1;
    if (dmem_req) dreq_cnt = dreq_cnt + 1;
    if (pc_write) last_len = ilen;
    if (bus_err && !bus_err_prev) tmo_len = wait_run;
    if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) wait_run = wait_run + 1;
    else wait_run = 0;
    bus_err_prev = bus_err;
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  // Instruction classes: 0 ALU/U/jump via WB, 1 load, 2 store, 3 branch, 4 unknown
  function automatic void model(input logic [6:0] op, output int cls,
                                output exp_t f, output logic [1:0] wb_pc);
    f = '0; cls = 0; wb_pc = 2'b00;
    case (op)
      7'd51:  f.alu_op = 2'b11;
      7'd19:  begin f.alu_op = 2'b10; f.alu_src = 2'd1; end
      7'd3:   begin cls = 1; f.alu_src = 2'd1; f.mem_to_reg = 3'b001; end
      7'd35:  begin cls = 2; f.alu_src = 2'd2; end
      7'd99:  begin cls = 3; f.alu_op = 2'b01; end
      7'd111: begin f.mem_to_reg = 3'b010; wb_pc = 2'b10; end
      7'd103: begin f.mem_to_reg = 3'b010; wb_pc = 2'b11; end
      7'd55:  f.mem_to_reg = 3'b011;
      7'd23:  f.mem_to_reg = 3'b100;
      default: cls = 4;
    endcase
  endfunction

  task automatic step(input logic r, input logic [6:0] op, input logic ir,
                      input logic dr, input logic bt, input exp_t e, input exp_t m);
    rst = r; opcode = op; imem_ready = ir; dmem_ready = dr; branch_taken = bt;
    exp_q.push_back(e);
    msk_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic halt_and_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e = '0; e.bus_err = m_bus_err; e.trap = m_trap;
      step(1'b0, rop(), rb(), rb(), rb(), e, m_full);
    end
    e = '0;
    step(1'b1, rop(), rb(), rb(), rb(), e, m_strb);
    m_bus_err = 1'b0;
    m_trap    = 1'b0;
  endtask

  // Expected cycle-by-cycle timeline of one instruction, derived from its class
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input logic tk);
    exp_t base, f, e;
    int cls, nw;
    logic [1:0] wb_pc;
    base = '0; base.bus_err = m_bus_err; base.trap = m_trap;
    model(op, cls, f, wb_pc);
    f.bus_err = m_bus_err; f.trap = m_trap;
    nw = (iw < TMO) ? iw : TMO;
    for (int i = 0; i < nw; i++) begin
      e = base; e.imem_req = 1'b1;
      step(1'b0, rop(), 1'b0, rb(), rb(), e, m_full);
    end
    if (iw >= TMO) begin m_bus_err = 1'b1; halt_and_reset(); return; end
    e = base; e.imem_req = 1'b1; e.ir_write = 1'b1;
    step(1'b0, rop(), 1'b1, rb(), rb(), e, m_full);
    step(1'b0, op, rb(), rb(), rb(), base, m_full);
    e = f;
    if (cls == 3) begin
      e.pc_write = 1'b1; e.pc_src = tk ? 2'b01 : 2'b00;
      step(1'b0, rop(), rb(), rb(), tk, e, m_full);
      return;
    end
    if (cls == 4) begin
`ifdef ILLEGAL_TRAP_EN
      step(1'b0, rop(), rb(), rb(), rb(), e, m_full);
      m_trap = 1'b1;
      halt_and_reset();
`else
      e.pc_write = 1'b1;
      step(1'b0, rop(), rb(), rb(), rb(), e, m_full);
`endif
      return;
    end
    step(1'b0, rop(), rb(), rb(), rb(), e, m_full);
    if (cls == 1 || cls == 2) begin
      nw = (dw < TMO) ? dw : TMO;
      for (int i = 0; i < nw; i++) begin
        e = f; e.dmem_req = 1'b1; e.mem_read = (cls == 1); e.mem_write = (cls == 2);
        step(1'b0, rop(), rb(), 1'b0, rb(), e, m_full);
      end
      if (dw >= TMO) begin m_bus_err = 1'b1; halt_and_reset(); return; end
      e = f; e.dmem_req = 1'b1; e.mem_read = (cls == 1); e.mem_write = (cls == 2);
      if (cls == 2) e.pc_write = 1'b1;
      step(1'b0, rop(), rb(), 1'b1, rb(), e, m_full);
      if (cls == 2) return;
    end
    e = f; e.reg_write = 1'b1; e.pc_write = 1'b1; e.pc_src = wb_pc;
    step(1'b0, rop(), rb(), rb(), rb(), e, m_full);
  endtask

  task automatic pin(input string name, input int act, input int expv);
    n_cmp = n_cmp + 1;
    if (act != expv) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  logic [6:0] known_ops [9] = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd111, 7'd103, 7'd55, 7'd23};

  initial begin
    exp_t e, fdummy;
    int cls, iw, dw, r;
    logic [1:0] pdummy;
    logic [6:0] op;
    m_full = '1;
    m_strb = '1; m_strb.bus_err = 1'b0; m_strb.trap = 1'b0;
    rst = 1'b1; opcode = 7'd0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;
    e = '0;
    step(1'b1, 7'd0, 1'b1, 1'b1, 1'b0, e, m_full);

    run_instr(7'd51, 0, 0, 1'b0);  pin("r_type_len", last_len, 4);
    run_instr(7'd3, 0, 3, 1'b0);   pin("load_len", last_len, 8);
    pin("load_dmem_req_cycles", dreq_cnt, 4);
    run_instr(7'd99, 0, 0, 1'b1);  pin("branch_taken_len", last_len, 3);
    run_instr(7'd99, 2, 0, 1'b0);  pin("branch_not_taken_len", last_len, 3);
    run_instr(7'd35, 0, 0, 1'b0);  pin("store_len", last_len, 4);
    run_instr(7'd111, 0, 0, 1'b0); pin("jal_len", last_len, 4);
    run_instr(7'd103, 1, 0, 1'b0);
    run_instr(7'd55, 0, 0, 1'b0);
    run_instr(7'd23, 0, 0, 1'b0);
    run_instr(7'd19, 15, 0, 1'b0);
    run_instr(7'd3, 0, 15, 1'b0);
`ifndef ILLEGAL_TRAP_EN
    run_instr(7'h7F, 0, 0, 1'b0);  pin("unknown_nop_len", last_len, 3);
`else
    run_instr(7'h7F, 0, 0, 1'b0);
`endif
    run_instr(7'd51, 0, 0, 1'b0);

    // R-type aborted by reset in the cycle it would write back
    e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1;
    step(1'b0, rop(), 1'b1, 1'b0, 1'b0, e, m_full);
    e = '0;
    step(1'b0, 7'd51, 1'b0, 1'b0, 1'b0, e, m_full);
    e = '0; e.alu_op = 2'b11;
    step(1'b0, rop(), 1'b0, 1'b0, 1'b0, e, m_full);
    e = '0;
    step(1'b1, rop(), 1'b1, 1'b1, 1'b0, e, m_strb);
    run_instr(7'd19, 0, 0, 1'b0);

    run_instr(7'd51, 16, 0, 1'b0); pin("imem_timeout_wait_cycles", tmo_len, 16);
    run_instr(7'd35, 0, 16, 1'b0); pin("dmem_timeout_wait_cycles", tmo_len, 16);
    run_instr(7'd51, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 18) op = known_ops[r % 9];
      else begin
        do begin op = rop(); model(op, cls, fdummy, pdummy); end while (cls != 4);
      end
      r = int'($urandom_range(0, 39));
      iw = (r == 0) ? 16 : (r == 1) ? 15 : (r < 10) ? int'($urandom_range(1, 3)) : 0;
      r = int'($urandom_range(0, 39));
      dw = (r == 0) ? 16 : (r == 1) ? 15 : (r < 10) ? int'($urandom_range(1, 3)) : 0;
      run_instr(op, iw, dw, rb());
    end

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
